morra_match_controller: RTL and testbench
=========================================

Name: morra_match_controller

Overview:
- Sequences the MorraCinese game core (2-bit moves P1/P2, START, results ROUND/GAME).
- Collects one move per player per round through valid/ready handshakes and issues a START pulse at match begin.
- Fires each round into the core for exactly one cycle, then samples the result. Exposes round/match status to the host logic.
- Sits between the player input front-ends and the game core.

Parameters:
TIMEOUT_CYCLES, 64, cycles allowed in COLLECT after the first move is captured before the round is abandoned
RCNT_W, 6, width of the rounds_played counter (saturating)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
new_match  input  1  pulse: start a new match (aborts any match in progress)
p1_valid  input  1  player 1 move valid
p1_move  input  2  player 1 move (01 rock, 10 paper, 11 scissors, 00 illegal)
p1_ready  output  1  controller can accept a player 1 move
p2_valid  input  1  player 2 move valid
p2_move  input  2  player 2 move (same encoding)
p2_ready  output  1  controller can accept a player 2 move
core_p1  output  2  to core P1
core_p2  output  2  to core P2
core_start  output  1  to core START
core_round  input  2  from core ROUND (00 none, 01 P1 wins, 10 P2 wins, 11 draw)
core_game  input  2  from core GAME (00 ongoing, 01 P1, 10 P2, 11 draw)
round_done  output  1  one-cycle pulse when a round result is sampled
last_round  output  2  last sampled core_round
match_over  output  1  high from match end until the next new_match
winner  output  2  core_game captured at match end
rounds_played  output  RCNT_W  rounds fired this match, saturating
timeout  output  1  one-cycle pulse when a round is abandoned
bad_move  output  1  one-cycle pulse when a 00 move is offered
p1_wins, p2_wins, draws  output  RCNT_W each  statistics (see Optional Feature)

Behaviour:
- Reset (rst_n=0, async): state IDLE; all outputs 0; captured moves cleared; counters 0.
- core_p1 and core_p2 are 00 in every state except FIRE. A 00 move pair is a no-op round for the core.
- IDLE:
  - ready outputs low.
  - new_match goes to START.
- START (1 cycle):
  - core_start=1.
  - Clears rounds_played, match_over, winner, last_round and the stats counters.
  - Then goes to COLLECT.
- COLLECT:
  - pN_ready=1 while player N's move is not yet captured.
  - Capture on pN_valid & pN_ready & pN_move!=00.
  - pN_valid & pN_ready & pN_move==00: move not captured, bad_move pulses, ready stays high.
  - Both moves captured: go to FIRE on the next cycle.
  - Both players may be captured in the same cycle.
- Timeout:
  - The timer starts on the first capture and counts every cycle in COLLECT.
  - When it reaches TIMEOUT_CYCLES-1 with one move still missing: clear both captured moves, pulse timeout, stay in COLLECT, reset the timer.
  - A capture of the missing move in the expiry cycle wins over the timeout.
- FIRE (1 cycle):
  - Drives the captured moves on core_p1/core_p2.
  - rounds_played increments, holding at 2^RCNT_W-1.
  - Goes to RESULT.
- RESULT (1 cycle):
  - Samples core_round into last_round and pulses round_done.
  - core_game!=00: match_over=1, winner=core_game, go to DONE.
  - Otherwise go to COLLECT with the captured moves cleared.
- DONE:
  - ready outputs low; match outputs hold.
  - new_match goes to START.
- new_match in any state (COLLECT, FIRE, RESULT included) goes to START on the next edge. Captured moves are discarded and no round_done is issued for the aborted round.
- Round latency: the second capture edge is followed by FIRE (+1 cycle) and RESULT (+2 cycles); round_done is asserted in RESULT.

Optional Feature:
- Macro: MORRA_STATS_EN.
- Defined:
  - In RESULT, core_round 01/10/11 increments p1_wins/p2_wins/draws respectively; each saturates at 2^RCNT_W-1; 00 increments nothing.
  - All three clear in START.
- Undefined: p1_wins, p2_wins and draws are tied to 0 and no counter logic is built.

Test Plan:
- Reset then new_match: core_start=1 for exactly 1 cycle, then p1_ready=p2_ready=1; all status outputs 0.
- p1 01, then p2 10 two cycles later: FIRE drives core_p1=01, core_p2=10 for 1 cycle; rounds_played=1; with core_round=10 returned, round_done pulses and last_round=10.
- p1_move=00 with p1_valid: bad_move pulses, p1_ready stays 1, no FIRE; a following 11 is accepted.
- TIMEOUT_CYCLES=4, p1 captured and p2 silent: timeout pulses 3 cycles after the capture, both ready=1 again, rounds_played unchanged.
- core_game=01 sampled in RESULT: match_over=1, winner=01, readys low; new_match then clears them via START.
- new_match asserted during FIRE: START follows, no round_done; with MORRA_STATS_EN, after three rounds returning 01, 01, 11: p1_wins=2, draws=1.

Source files
------------

// File: rtl/morra_match_controller.sv
// Morra match controller: collects one move per player, fires each round into the MorraCinese core and tracks match status.
// Define MORRA_STATS_EN to build the p1_wins/p2_wins/draws statistics counters (tied to 0 otherwise).
module morra_match_controller #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int RCNT_W         = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              new_match,
  input  logic              p1_valid,
  input  logic [1:0]        p1_move,
  output logic              p1_ready,
  input  logic              p2_valid,
  input  logic [1:0]        p2_move,
  output logic              p2_ready,
  output logic [1:0]        core_p1,
  output logic [1:0]        core_p2,
  output logic              core_start,
  input  logic [1:0]        core_round,
  input  logic [1:0]        core_game,
  output logic              round_done,
  output logic [1:0]        last_round,
  output logic              match_over,
  output logic [1:0]        winner,
  output logic [RCNT_W-1:0] rounds_played,
  output logic              timeout,
  output logic              bad_move,
  output logic [RCNT_W-1:0] p1_wins,
  output logic [RCNT_W-1:0] p2_wins,
  output logic [RCNT_W-1:0] draws
);

  localparam int                TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]     TLAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RCNT_W-1:0] RMAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_COLLECT, S_FIRE, S_RESULT, S_DONE
  } state_t;

  state_t        state;
  logic [1:0]    cap1, cap2;
  logic [TW-1:0] timer;
  logic          timer_run;

  logic in_collect, offer1, offer2, take1, take2, bad1, bad2;
  logic have1, have2, both, expire;

  // A move of 00 is never captured, so a non-zero capture register means "captured".
  assign in_collect = (state == S_COLLECT);
  assign offer1     = in_collect && p1_valid && p1_ready;
  assign offer2     = in_collect && p2_valid && p2_ready;
  assign take1      = offer1 && (p1_move != 2'b00);
  assign take2      = offer2 && (p2_move != 2'b00);
  assign bad1       = offer1 && (p1_move == 2'b00);
  assign bad2       = offer2 && (p2_move == 2'b00);
  assign have1      = (cap1 != 2'b00) || take1;
  assign have2      = (cap2 != 2'b00) || take2;
  assign both       = have1 && have2;
  assign expire     = timer_run && (timer == TLAST) && !both;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cap1          <= 2'b00;
      cap2          <= 2'b00;
      timer         <= '0;
      timer_run     <= 1'b0;
      p1_ready      <= 1'b0;
      p2_ready      <= 1'b0;
      core_p1       <= 2'b00;
      core_p2       <= 2'b00;
      core_start    <= 1'b0;
      round_done    <= 1'b0;
      last_round    <= 2'b00;
      match_over    <= 1'b0;
      winner        <= 2'b00;
      rounds_played <= '0;
      timeout       <= 1'b0;
      bad_move      <= 1'b0;
    end else begin
      core_start <= 1'b0;
      round_done <= 1'b0;
      timeout    <= 1'b0;
      bad_move   <= 1'b0;
      if (new_match) begin
        state         <= S_START;
        core_start    <= 1'b1;
        cap1          <= 2'b00;
        cap2          <= 2'b00;
        timer         <= '0;
        timer_run     <= 1'b0;
        p1_ready      <= 1'b0;
        p2_ready      <= 1'b0;
        core_p1       <= 2'b00;
        core_p2       <= 2'b00;
        last_round    <= 2'b00;
        match_over    <= 1'b0;
        winner        <= 2'b00;
        rounds_played <= '0;
      end else begin
        case (state)
          S_START: begin
            state    <= S_COLLECT;
            p1_ready <= 1'b1;
            p2_ready <= 1'b1;
          end
          S_COLLECT: begin
            bad_move <= bad1 | bad2;
            if (take1) cap1 <= p1_move;
            if (take2) cap2 <= p2_move;
            // A capture completing the pair in the expiry cycle takes priority over the timeout.
            if (both) begin
              state     <= S_FIRE;
              core_p1   <= take1 ? p1_move : cap1;
              core_p2   <= take2 ? p2_move : cap2;
              p1_ready  <= 1'b0;
              p2_ready  <= 1'b0;
              timer_run <= 1'b0;
              timer     <= '0;
              if (rounds_played != RMAX) rounds_played <= rounds_played + 1'b1;
            end else if (expire) begin
              cap1      <= 2'b00;
              cap2      <= 2'b00;
              timeout   <= 1'b1;
              timer_run <= 1'b0;
              timer     <= '0;
              p1_ready  <= 1'b1;
              p2_ready  <= 1'b1;
            end else begin
              p1_ready <= !have1;
              p2_ready <= !have2;
              if (timer_run) begin
                timer <= timer + 1'b1;
              end else if (take1 || take2) begin
                timer_run <= 1'b1;
                timer     <= TW'(1);
              end
            end
          end
          S_FIRE: begin
            state      <= S_RESULT;
            core_p1    <= 2'b00;
            core_p2    <= 2'b00;
            cap1       <= 2'b00;
            cap2       <= 2'b00;
            round_done <= 1'b1;
          end
          S_RESULT: begin
            last_round <= core_round;
            if (core_game != 2'b00) begin
              state      <= S_DONE;
              match_over <= 1'b1;
              winner     <= core_game;
            end else begin
              state    <= S_COLLECT;
              p1_ready <= 1'b1;
              p2_ready <= 1'b1;
            end
          end
          S_IDLE, S_DONE: begin
            p1_ready <= 1'b0;
            p2_ready <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef MORRA_STATS_EN
  // Per-outcome counters follow the same clear and sample points as last_round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_wins <= '0;
      p2_wins <= '0;
      draws   <= '0;
    end else if (new_match) begin
      p1_wins <= '0;
      p2_wins <= '0;
      draws   <= '0;
    end else if (state == S_RESULT) begin
      case (core_round)
        2'b01:   if (p1_wins != RMAX) p1_wins <= p1_wins + 1'b1;
        2'b10:   if (p2_wins != RMAX) p2_wins <= p2_wins + 1'b1;
        2'b11:   if (draws != RMAX)   draws   <= draws + 1'b1;
        default: ;
      endcase
    end
  end
`else
  assign p1_wins = '0;
  assign p2_wins = '0;
  assign draws   = '0;
`endif

endmodule

// File: tb/tb_morra_match_controller.sv
// Scoreboard bench for morra_match_controller: stimulus pushes expected events, a monitor pops and compares them.
module tb_morra_match_controller;

  localparam int RCNT_W = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              new_match;
  logic              p1_valid, p2_valid;
  logic [1:0]        p1_move, p2_move;
  logic              p1_ready, p2_ready;
  logic [1:0]        core_p1, core_p2;
  logic              core_start;
  logic [1:0]        core_round, core_game;
  logic              round_done;
  logic [1:0]        last_round;
  logic              match_over;
  logic [1:0]        winner;
  logic [RCNT_W-1:0] rounds_played;
  logic              timeout, bad_move;
  logic [RCNT_W-1:0] p1_wins, p2_wins, draws;

  int vec_count   = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [1:0]        p1;
    logic [1:0]        p2;
    logic [RCNT_W-1:0] rc;
  } fire_t;

  typedef struct packed {
    logic [1:0] lr;
    logic       over;
    logic [1:0] win;
  } done_t;

  fire_t             fire_q[$];
  done_t             done_q[$];
  int                start_q[$];
  logic [RCNT_W-1:0] tmo_q[$];
  logic [1:0]        bad_q[$];

  morra_match_controller #(.TIMEOUT_CYCLES(4), .RCNT_W(RCNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .new_match(new_match),
    .p1_valid(p1_valid), .p1_move(p1_move), .p1_ready(p1_ready),
    .p2_valid(p2_valid), .p2_move(p2_move), .p2_ready(p2_ready),
    .core_p1(core_p1), .core_p2(core_p2), .core_start(core_start),
    .core_round(core_round), .core_game(core_game),
    .round_done(round_done), .last_round(last_round),
    .match_over(match_over), .winner(winner), .rounds_played(rounds_played),
    .timeout(timeout), .bad_move(bad_move),
    .p1_wins(p1_wins), .p2_wins(p2_wins), .draws(draws)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    vec_count++;
    miscompares++;
    $display("[TB] FAIL unexpected_%s: actual event seen, required none at %0t", name, $time);
  endtask

  // Inputs change only at falling edges and are held across the next rising edge.
  task automatic applyStimulus(input logic nm, input logic v1, input logic [1:0] m1,
                               input logic v2, input logic [1:0] m2);
    new_match = nm;
    p1_valid  = v1;
    p1_move   = m1;
    p2_valid  = v2;
    p2_move   = m2;
    @(negedge clk);
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
  endtask

  task automatic playRound(input logic [1:0] m1, input logic [1:0] m2, input logic [1:0] cr,
                           input logic [1:0] cg, input logic [RCNT_W-1:0] rc,
                           input logic over, input logic [1:0] win);
    core_round = cr;
    core_game  = cg;
    fire_q.push_back('{p1: m1, p2: m2, rc: rc});
    done_q.push_back('{lr: cr, over: over, win: win});
    applyStimulus(1'b0, 1'b1, m1, 1'b1, m2);
    idle();
    waitCycles(1);
  endtask

  // Monitor: every output event must match the oldest expectation of its kind.
  initial begin : monitor
    fire_t             f;
    done_t             pend;
    logic              pend_v;
    logic [1:0]        br;
    logic [RCNT_W-1:0] tr;
    pend_v = 1'b0;
    forever begin
      @(negedge clk);
      if (pend_v) begin
        checkOutput("last_round", 32'(last_round), 32'(pend.lr));
        checkOutput("match_over", 32'(match_over), 32'(pend.over));
        checkOutput("winner", 32'(winner), 32'(pend.win));
        pend_v = 1'b0;
      end
      if (rst_n) begin
        if (core_start) begin
          if (start_q.size() == 0) unexpected("core_start");
          else begin
            void'(start_q.pop_front());
            checkOutput("start_rounds_played", 32'(rounds_played), 32'd0);
            checkOutput("start_status", {27'd0, match_over, winner, last_round}, 32'd0);
            checkOutput("start_core_moves", {28'd0, core_p1, core_p2}, 32'd0);
          end
        end
        if (core_p1 != 2'b00 || core_p2 != 2'b00) begin
          if (fire_q.size() == 0) unexpected("fire");
          else begin
            f = fire_q.pop_front();
            checkOutput("fire_core_p1", 32'(core_p1), 32'(f.p1));
            checkOutput("fire_core_p2", 32'(core_p2), 32'(f.p2));
            checkOutput("fire_rounds_played", 32'(rounds_played), 32'(f.rc));
          end
        end
        if (round_done) begin
          if (done_q.size() == 0) unexpected("round_done");
          else begin
            pend   = done_q.pop_front();
            pend_v = 1'b1;
          end
        end
        if (timeout) begin
          if (tmo_q.size() == 0) unexpected("timeout");
          else begin
            tr = tmo_q.pop_front();
            checkOutput("timeout_readys", {30'd0, p1_ready, p2_ready}, 32'd3);
            checkOutput("timeout_rounds_played", 32'(rounds_played), 32'(tr));
          end
        end
        if (bad_move) begin
          if (bad_q.size() == 0) unexpected("bad_move");
          else begin
            br = bad_q.pop_front();
            checkOutput("bad_move_readys", {30'd0, p1_ready, p2_ready}, 32'(br));
            checkOutput("bad_move_no_fire", 32'(core_p1), 32'd0);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: actual still running, required finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    rst_n      = 1'b0;
    core_round = 2'b00;
    core_game  = 2'b00;
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
    waitCycles(1);
    checkOutput("reset_ctrl", {26'd0, core_start, p1_ready, p2_ready, round_done, timeout, bad_move}, 32'd0);
    checkOutput("reset_status", {27'd0, match_over, winner, last_round}, 32'd0);
    checkOutput("reset_rounds_played", 32'(rounds_played), 32'd0);
    rst_n = 1'b1;
    waitCycles(1);
    checkOutput("idle_readys", {30'd0, p1_ready, p2_ready}, 32'd0);

    $display("[TB] new_match from IDLE");
    start_q.push_back(1);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 2'b00);
    checkOutput("start_pulse", 32'(core_start), 32'd1);
    idle();
    checkOutput("start_one_cycle", 32'(core_start), 32'd0);
    checkOutput("collect_readys", {30'd0, p1_ready, p2_ready}, 32'd3);

    $display("[TB] p1 rock, p2 paper two cycles later");
    core_round = 2'b10;
    fire_q.push_back('{p1: 2'b01, p2: 2'b10, rc: 6'd1});
    done_q.push_back('{lr: 2'b10, over: 1'b0, win: 2'b00});
    applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 2'b00);
    checkOutput("p1_ready_after_capture", {30'd0, p1_ready, p2_ready}, 32'd1);
    idle();
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, 2'b10);
    idle();
    checkOutput("round_done_in_result", 32'(round_done), 32'd1);
    waitCycles(1);
    checkOutput("readys_after_round", {30'd0, p1_ready, p2_ready}, 32'd3);

    $display("[TB] illegal 00 move then scissors");
    bad_q.push_back(2'b11);
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 2'b00);
    checkOutput("bad_p1_ready", 32'(p1_ready), 32'd1);
    core_round = 2'b10;
    fire_q.push_back('{p1: 2'b11, p2: 2'b01, rc: 6'd2});
    done_q.push_back('{lr: 2'b10, over: 1'b0, win: 2'b00});
    applyStimulus(1'b0, 1'b1, 2'b11, 1'b0, 2'b00);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, 2'b01);
    idle();
    waitCycles(1);

    $display("[TB] p2 silent until timeout");
    tmo_q.push_back(6'd2);
    applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 2'b00);
    waitCycles(2);
    checkOutput("timeout_not_early", 32'(timeout), 32'd0);
    waitCycles(1);
    checkOutput("timeout_pulse", 32'(timeout), 32'd1);

    $display("[TB] missing move arrives in the expiry cycle");
    core_round = 2'b11;
    fire_q.push_back('{p1: 2'b10, p2: 2'b10, rc: 6'd3});
    done_q.push_back('{lr: 2'b11, over: 1'b0, win: 2'b00});
    applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 2'b00);
    idle();
    idle();
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, 2'b10);
    checkOutput("expiry_capture_no_timeout", 32'(timeout), 32'd0);
    idle();
    waitCycles(1);

    $display("[TB] match ends with P1 winning");
    playRound(2'b10, 2'b01, 2'b01, 2'b01, 6'd4, 1'b1, 2'b01);
    checkOutput("done_readys", {30'd0, p1_ready, p2_ready}, 32'd0);
    core_round = 2'b00;
    core_game  = 2'b00;
    applyStimulus(1'b0, 1'b1, 2'b01, 1'b1, 2'b01);
    checkOutput("done_holds_match_over", 32'(match_over), 32'd1);
    checkOutput("done_holds_winner", 32'(winner), 32'd1);
    start_q.push_back(1);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 2'b00);
    idle();
    checkOutput("restart_readys", {30'd0, p1_ready, p2_ready}, 32'd3);

    $display("[TB] new_match during FIRE aborts the round");
    core_round = 2'b01;
    fire_q.push_back('{p1: 2'b01, p2: 2'b01, rc: 6'd1});
    start_q.push_back(1);
    applyStimulus(1'b0, 1'b1, 2'b01, 1'b1, 2'b01);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 2'b00);
    idle();
    waitCycles(2);
    checkOutput("abort_rounds_played", 32'(rounds_played), 32'd0);
    checkOutput("abort_readys", {30'd0, p1_ready, p2_ready}, 32'd3);

    $display("[TB] three rounds for statistics");
    playRound(2'b10, 2'b01, 2'b01, 2'b00, 6'd1, 1'b0, 2'b00);
    playRound(2'b01, 2'b11, 2'b01, 2'b00, 6'd2, 1'b0, 2'b00);
    playRound(2'b11, 2'b11, 2'b11, 2'b00, 6'd3, 1'b0, 2'b00);
`ifdef MORRA_STATS_EN
    checkOutput("stats_p1_wins", 32'(p1_wins), 32'd2);
    checkOutput("stats_p2_wins", 32'(p2_wins), 32'd0);
    checkOutput("stats_draws", 32'(draws), 32'd1);
`else
    checkOutput("stats_tied_zero", {p1_wins, p2_wins, draws}, 32'd0);
`endif
    checkOutput("stats_rounds_played", 32'(rounds_played), 32'd3);

    waitCycles(3);
    checkOutput("pending_fire", 32'(fire_q.size()), 32'd0);
    checkOutput("pending_round_done", 32'(done_q.size()), 32'd0);
    checkOutput("pending_start", 32'(start_q.size()), 32'd0);
    checkOutput("pending_timeout", 32'(tmo_q.size()), 32'd0);
    checkOutput("pending_bad_move", 32'(bad_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
